// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state type, mode constants and the next-enabled-channel search.
//   S_MAN/S_AUTO  operating states of mux_scan_nto1
//   MODE_MAN/AUTO encodings of the mode input
//   next_en()     next enabled channel above cur, wrapping at nch
package mux_scan_pkg;

   typedef enum logic {S_MAN = 1'b0, S_AUTO = 1'b1} state_t;

   localparam logic MODE_MAN  = 1'b0;
   localparam logic MODE_AUTO = 1'b1;

   // Upper bound on channel count for the search; the loop is fixed-length so it unrolls.
   localparam int unsigned MAX_CH = 64;

   // Returns the first index after cur (wrapping past nch-1) whose mask bit is set.
   // Returns cur when no other channel is enabled.
   function automatic int unsigned next_en(input int unsigned cur, input int unsigned nch,
                                           input logic [MAX_CH-1:0] mask);
      int unsigned idx;
      logic found;
      next_en = cur;
      found = 1'b0;
      for (int unsigned i = 1; i <= MAX_CH; i++) begin
         idx = cur + i;
         if (idx >= nch) idx = idx - nch;
         if (!found && i <= nch && mask[idx[5:0]]) begin
            next_en = idx;
            found = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mux_scan_ptr.sv
// mux_scan_ptr: auto-scan channel pointer, dwell counter and wrap detection.
//   clk, rst    clock, asynchronous active-high reset
//   start       entering auto mode: pointer to first enabled channel, counter cleared
//   run         auto mode active; pointer and counter freeze while low
//   slot_free   output register can accept a sample this edge
//   mask        per-channel enable (all ones when masking is not built in)
//   ptr         current channel
//   fire        capture ptr's channel on this edge
//   wrap        pointer search passes the top channel on this edge
module mux_scan_ptr
   import mux_scan_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int DWELL = 4,
   localparam int SELW = $clog2(NCH),
   localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            run,
   input  logic            slot_free,
   input  logic [NCH-1:0]  mask,
   output logic [SELW-1:0] ptr,
   output logic            fire,
   output logic            wrap
);

   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [SELW-1:0]   ptr_q, ptr_d, nxt, first;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [MAX_CH-1:0] mask_w;
   logic              any_en, due;

   always_comb begin
      mask_w = MAX_CH'(mask);
      any_en = |mask;
      nxt = SELW'(next_en(32'(ptr_q), NCH, mask_w));
      // Searching upward from the top index lands on the lowest enabled channel.
      first = SELW'(next_en(NCH - 1, NCH, mask_w));
      // Dwell complete and the output can take it; backpressure parks the counter at LAST.
      due = run && any_en && (cnt_q == LAST) && slot_free;
      // A channel masked off mid-dwell is stepped over without a capture.
      fire = due && mask[ptr_q];
      wrap = due && (nxt <= ptr_q);
      ptr_d = start ? first : (due ? nxt : ptr_q);
      cnt_d = (start || (run && !any_en) || due) ? '0 :
              (!run || cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: N-channel registered multiplexer, manual or round-robin auto-scan, valid/ready output.
//   clk, rst   clock, asynchronous active-high reset
//   mode       0 manual (sel_in picks the channel), 1 auto-scan with DWELL cycles per channel
//   sel_in     manual channel select
//   d_in       packed channel data, channel k at d_in[k*W +: W]
//   out_ready  downstream accepts the held sample
//   out_valid  q/q_sel hold a sample
//   q, q_sel   sample data and its source channel
//   scan_wrap  one-cycle pulse when the auto pointer wraps past the top channel
//   sel_err    one-cycle pulse when a manual capture selected a non-existent (or masked) channel
//   ch_mask    channel enables, present only when MUX_SCAN_MASK_EN is defined
module mux_scan_nto1
   import mux_scan_pkg::*;
#(
   parameter int NCH   = 4,
   parameter int W     = 4,
   parameter int DWELL = 4,
   localparam int SELW = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [SELW-1:0]  sel_in,
   input  logic [NCH*W-1:0] d_in,
   input  logic             out_ready,
`ifdef MUX_SCAN_MASK_EN
   input  logic [NCH-1:0]   ch_mask,
`endif
   output logic             out_valid,
   output logic [W-1:0]     q,
   output logic [SELW-1:0]  q_sel,
   output logic             scan_wrap,
   output logic             sel_err
);

   state_t          state_q, state_d;
   logic [W-1:0]    ch [NCH];
   logic [W-1:0]    q_q, q_d;
   logic [SELW-1:0] q_sel_q, q_sel_d, ptr;
   logic            out_valid_q, out_valid_d;
   logic            scan_wrap_q, scan_wrap_d;
   logic            sel_err_q, sel_err_d;
   logic            slot_free, man_cap, sel_bad, start, fire, wrap;
   logic [NCH-1:0]  mask;

`ifdef MUX_SCAN_MASK_EN
   assign mask = ch_mask;
`else
   assign mask = '1;
`endif

   always_comb begin
      for (int k = 0; k < NCH; k++) ch[k] = d_in[k*W +: W];
   end

   always_comb begin
      state_d = (mode == MODE_AUTO) ? S_AUTO : S_MAN;
      start = (state_q == S_MAN) && (state_d == S_AUTO);
      // A held sample is never overwritten; it may be replaced on the edge it transfers.
      slot_free = !out_valid_q || out_ready;
      man_cap = (state_q == S_MAN) && slot_free;
      sel_bad = (32'(sel_in) >= NCH) || !mask[sel_in];
      q_d = man_cap ? (sel_bad ? '0 : ch[sel_in]) : (fire ? ch[ptr] : q_q);
      q_sel_d = man_cap ? sel_in : (fire ? ptr : q_sel_q);
      out_valid_d = man_cap || fire || (out_valid_q && !out_ready);
      sel_err_d = man_cap && sel_bad;
      scan_wrap_d = wrap;
   end

   mux_scan_ptr #(
      .NCH   (NCH),
      .DWELL (DWELL)
   ) u_ptr (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .run       (state_q == S_AUTO),
      .slot_free (slot_free),
      .mask      (mask),
      .ptr       (ptr),
      .fire      (fire),
      .wrap      (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_MAN;
         q_q         <= '0;
         q_sel_q     <= '0;
         out_valid_q <= 1'b0;
         scan_wrap_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         q_sel_q     <= q_sel_d;
         out_valid_q <= out_valid_d;
         scan_wrap_q <= scan_wrap_d;
         sel_err_q   <= sel_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign q         = q_q;
   assign q_sel     = q_sel_q;
   assign scan_wrap = scan_wrap_q;
   assign sel_err   = sel_err_q;

endmodule
